intc_arbiter: RTL and testbench
===============================

# intc_arbiter

Interrupt controller feeding the single external interrupt line of the CP0 block in the pipelined CPU. Collects up to `N_SRC` device interrupt sources, latches them as pending, masks them, picks one winner, and raises it to CP0. It then holds off further requests until CP0 accepts the interrupt and the handler executes ERET. Software-visible mask, pending and mode registers are accessed through a small register port driven from the MTC0/MFC0 path.

## Interface
- `N_SRC`, 8: number of interrupt sources, 1..32.
- `ID_W`, 3: width of the source index; must satisfy 2^ID_W >= N_SRC.

- `clk` in 1: main clock.
- `rst` in 1: reset, synchronous, active-high.
- `src` in N_SRC: device interrupt inputs, synchronous to `clk`.
- `ir_taken` in 1: one-cycle pulse from CP0 when it accepts the interrupt and forces the jump.
- `eret` in 1: one-cycle pulse when ERET executes.
- `cfg_we` in 1: register write strobe.
- `cfg_re` in 1: register read strobe.
- `cfg_addr` in 2: register select; 0 MASK, 1 PEND, 2 ISR, 3 MODE.
- `cfg_wdata` in 32: write data.
- `cfg_rdata` out 32: read data, registered.
- `ir_out` out 1: interrupt request to CP0 `ir_in`.
- `ir_id` out ID_W: index of the requested or in-service source.
- `busy` out 1: high in REQ and SVC.

## Operation
- Registers, bits above N_SRC-1 read 0:
  - MASK: RW; 1 = enabled.
  - PEND: read; writing 1 to a bit clears it (W1C).
  - ISR: read-only; bit 31 = in service, low ID_W bits = `ir_id`.
  - MODE: RW; 1 = edge, 0 = level.
- Pending set rules:
  - Edge mode: bit set on a rising edge of `src[i]`, detected against a one-cycle registered copy.
  - Level mode: bit set every cycle `src[i]`=1.
  - Set has priority over any clear in the same cycle.
- Eligible = PEND & MASK.
- State machine IDLE / REQ / SVC:
  - IDLE: if any bit is eligible, latch the winner into `ir_id` and go to REQ.
  - REQ: `ir_out`=1.
    - On `ir_taken`: clear PEND[`ir_id`] (unless re-set that cycle) and go to SVC.
    - If MASK[`ir_id`] or PEND[`ir_id`] drops before `ir_taken`: return to IDLE with no request.
    - If both happen in the same cycle, `ir_taken` wins.
  - SVC: `ir_out`=0. On `eret`, go to IDLE.
  - `eret` in IDLE or REQ is ignored.
- Winner selection, fixed priority: lowest eligible index.
- `rst` in any state: return to IDLE and apply reset values next edge, including mid-REQ and mid-SVC.

## Timing
- Reset values:
  - `ir_out`=0, `ir_id`=0, `busy`=0, `cfg_rdata`=0.
  - MASK=0, PEND=0, MODE=all 1 (edge), state IDLE, rotation pointer 0.
  - Edge-detect history register = 0.
- Latency:
  - Source edge at cycle n sets PEND at edge n+1.
  - Transition to REQ at n+2; `ir_out` is a registered output, high from n+2.
- `ir_out` falls the cycle after the `ir_taken` edge. `ir_out` and `busy` are registered.
- Earliest next request after `eret` at cycle m: IDLE at m+1, `ir_out` at m+2.
- Register writes take effect at the next edge. A MASK write in the same cycle as an IDLE selection is not seen by that selection.
- `cfg_rdata` updates the edge after `cfg_re` and holds until the next `cfg_re`.
- Sources arriving during REQ or SVC stay pending and are not lost; there is no nesting.

## Configuration
- `INTC_RR_EN` defined: round-robin arbitration.
  - Search starts at a rotation pointer; the pointer is set to (`ir_id`+1) mod N_SRC on each `ir_taken`.
  - Pointer wraps from N_SRC-1 to 0.
- `INTC_RR_EN` undefined: fixed priority only (lowest index wins). No pointer register is built.

## Test plan
- Reset, MASK=0xFF, pulse `src[3]` at cycle 10:
  - PEND=0x08 at 11, `ir_out`=1 with `ir_id`=3 at 12.
  - `ir_taken` at 14 -> `ir_out`=0 and PEND=0 at 15.
  - `eret` at 20 -> IDLE at 21, `busy`=0.
- Rising edges on `src[5]` and `src[2]` in the same cycle, fixed priority:
  - `ir_id`=2 first.
  - After `ir_taken` then `eret`, `ir_id`=5 is raised 2 cycles after `eret`.
- With `INTC_RR_EN`, hold `src[0]` and `src[1]` in level mode:
  - Three take/eret rounds yield `ir_id` 0, 1, 0.
- In REQ for `src[4]`, write MASK=0x00 -> `ir_out`=0 next cycle, state IDLE, PEND[4] stays 1.
  - Write PEND=0x10 (W1C) -> PEND=0.
- Assert `rst` during SVC with PEND=0x40 -> next edge all outputs 0, PEND=0, MODE=0xFF.
  - `eret` afterwards has no effect.

Source files
------------

// File: rtl/intc_arbiter.sv
// Interrupt controller: latches, masks and arbitrates device sources onto the CP0 interrupt line.
// Define INTC_RR_EN for round-robin arbitration; fixed lowest-index priority otherwise.
module intc_arbiter #(
    parameter int unsigned N_SRC = 8,
    parameter int unsigned ID_W  = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [N_SRC-1:0]  src_i,
    input  logic              ir_taken_i,
    input  logic              eret_i,
    input  logic              cfg_we_i,
    input  logic              cfg_re_i,
    input  logic [1:0]        cfg_addr_i,
    input  logic [31:0]       cfg_wdata_i,
    output logic [31:0]       cfg_rdata_o,
    output logic              ir_out_o,
    output logic [ID_W-1:0]   ir_id_o,
    output logic              busy_o
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StReq  = 2'd1;
    localparam logic [1:0] StSvc  = 2'd2;

    localparam logic [1:0] AddrMask = 2'd0;
    localparam logic [1:0] AddrPend = 2'd1;
    localparam logic [1:0] AddrIsr  = 2'd2;
    localparam logic [1:0] AddrMode = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [N_SRC-1:0] mask_q, mask_d;
    logic [N_SRC-1:0] pend_q, pend_d;
    logic [N_SRC-1:0] mode_q, mode_d;
    logic [N_SRC-1:0] src_q;
    logic [ID_W-1:0]  ir_id_q, ir_id_d;
    logic             ir_out_q, ir_out_d;
    logic             busy_q, busy_d;
    logic [31:0]      rdata_q, rdata_d;

    logic [N_SRC-1:0] elig;
    logic [N_SRC-1:0] rot;
    logic [N_SRC-1:0] pend_set;
    logic [N_SRC-1:0] wr_clr;
    logic [N_SRC-1:0] take_clr;
    logic [ID_W-1:0]  base;
    logic [ID_W-1:0]  win_id;
    logic             take;
    logic             unused_wdata;

    assign unused_wdata = ^cfg_wdata_i;
    assign elig = pend_q & mask_q;
    assign take = (state_q == StReq) && ir_taken_i;

`ifdef INTC_RR_EN
    logic [ID_W-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (take) begin
            ptr_d = (ir_id_q == ID_W'(N_SRC - 1)) ? '0 : ir_id_q + ID_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign base = ptr_q;
`else
    assign base = '0;
`endif

    // Rotate the eligible vector so the search always runs from bit 0 upward.
    always_comb begin
        int r;
        int s;
        rot = N_SRC'({elig, elig} >> base);
        r   = 0;
        for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
            if (rot[i]) begin
                r = i;
            end
        end
        s = int'(base) + r;
        if (s >= int'(N_SRC)) begin
            s = s - int'(N_SRC);
        end
        win_id = ID_W'(s);
    end

    always_comb begin
        state_d  = state_q;
        ir_id_d  = ir_id_q;
        take_clr = '0;
        case (state_q)
            StIdle: begin
                if (|elig) begin
                    state_d = StReq;
                    ir_id_d = win_id;
                end
            end
            StReq: begin
                if (ir_taken_i) begin
                    state_d           = StSvc;
                    take_clr[ir_id_q] = 1'b1;
                end else if (!mask_q[ir_id_q] || !pend_q[ir_id_q]) begin
                    state_d = StIdle;
                end
            end
            StSvc: begin
                if (eret_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        ir_out_d = (state_d == StReq);
        busy_d   = (state_d != StIdle);
    end

    // Set wins over W1C and take-clear so a source re-asserting that cycle is never lost.
    always_comb begin
        pend_set = (mode_q & src_i & ~src_q) | (~mode_q & src_i);
        wr_clr   = (cfg_we_i && cfg_addr_i == AddrPend) ? cfg_wdata_i[N_SRC-1:0] : '0;
        pend_d   = (pend_q & ~(wr_clr | take_clr)) | pend_set;
        mask_d   = (cfg_we_i && cfg_addr_i == AddrMask) ? cfg_wdata_i[N_SRC-1:0] : mask_q;
        mode_d   = (cfg_we_i && cfg_addr_i == AddrMode) ? cfg_wdata_i[N_SRC-1:0] : mode_q;
    end

    always_comb begin
        rdata_d = rdata_q;
        if (cfg_re_i) begin
            rdata_d = '0;
            unique case (cfg_addr_i)
                AddrMask: rdata_d[N_SRC-1:0] = mask_q;
                AddrPend: rdata_d[N_SRC-1:0] = pend_q;
                AddrIsr: begin
                    rdata_d[31]       = (state_q == StSvc);
                    rdata_d[ID_W-1:0] = ir_id_q;
                end
                AddrMode: rdata_d[N_SRC-1:0] = mode_q;
                default:  rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            mask_q   <= '0;
            pend_q   <= '0;
            mode_q   <= '1;
            src_q    <= '0;
            ir_id_q  <= '0;
            ir_out_q <= 1'b0;
            busy_q   <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            pend_q   <= pend_d;
            mode_q   <= mode_d;
            src_q    <= src_i;
            ir_id_q  <= ir_id_d;
            ir_out_q <= ir_out_d;
            busy_q   <= busy_d;
            rdata_q  <= rdata_d;
        end
    end

    assign cfg_rdata_o = rdata_q;
    assign ir_out_o    = ir_out_q;
    assign ir_id_o     = ir_id_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_intc_arbiter.sv
// Directed bench for intc_arbiter; expected values are hand-derived from the register-level behaviour.
module tb_intc_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [7:0]  src_i;
    logic        ir_taken_i;
    logic        eret_i;
    logic        cfg_we_i;
    logic        cfg_re_i;
    logic [1:0]  cfg_addr_i;
    logic [31:0] cfg_wdata_i;
    logic [31:0] cfg_rdata_o;
    logic        ir_out_o;
    logic [2:0]  ir_id_o;
    logic        busy_o;

    int checks   = 0;
    int failures = 0;
    logic [31:0] rd_val;
    logic [2:0]  rr_exp [3];

    intc_arbiter #(.N_SRC(8), .ID_W(3)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .src_i       (src_i),
        .ir_taken_i  (ir_taken_i),
        .eret_i      (eret_i),
        .cfg_we_i    (cfg_we_i),
        .cfg_re_i    (cfg_re_i),
        .cfg_addr_i  (cfg_addr_i),
        .cfg_wdata_i (cfg_wdata_i),
        .cfg_rdata_o (cfg_rdata_o),
        .ir_out_o    (ir_out_o),
        .ir_id_o     (ir_id_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] addr, input logic [31:0] data);
        cfg_we_i    = 1'b1;
        cfg_addr_i  = addr;
        cfg_wdata_i = data;
        cyc();
        cfg_we_i    = 1'b0;
    endtask

    task automatic rd(input logic [1:0] addr, output logic [31:0] data);
        cfg_re_i   = 1'b1;
        cfg_addr_i = addr;
        cyc();
        cfg_re_i   = 1'b0;
        data       = cfg_rdata_o;
    endtask

    initial begin
`ifdef INTC_RR_EN
        rr_exp[0] = 3'd0; rr_exp[1] = 3'd1; rr_exp[2] = 3'd0;
`else
        rr_exp[0] = 3'd0; rr_exp[1] = 3'd0; rr_exp[2] = 3'd0;
`endif
        rst_i = 1'b1; src_i = '0; ir_taken_i = 1'b0; eret_i = 1'b0;
        cfg_we_i = 1'b0; cfg_re_i = 1'b0; cfg_addr_i = '0; cfg_wdata_i = '0;
        cyc();
        cyc();
        rst_i = 1'b0;

        // Reset state
        chk("rst_ir_out", 32'(ir_out_o), 32'd0);
        chk("rst_ir_id", 32'(ir_id_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_rdata", cfg_rdata_o, 32'd0);
        rd(2'd3, rd_val); chk("rst_mode", rd_val, 32'hFF);
        rd(2'd0, rd_val); chk("rst_mask", rd_val, 32'h00);
        rd(2'd1, rd_val); chk("rst_pend", rd_val, 32'h00);

        // Single edge source on bit 3
        wr(2'd0, 32'hFF);
        src_i = 8'h08;
        cyc();
        src_i = 8'h00;
        chk("s3_no_req_yet", 32'(ir_out_o), 32'd0);
        rd(2'd1, rd_val);
        chk("s3_pend", rd_val, 32'h08);
        chk("s3_ir_out", 32'(ir_out_o), 32'd1);
        chk("s3_ir_id", 32'(ir_id_o), 32'd3);
        chk("s3_busy", 32'(busy_o), 32'd1);
        cyc();
        chk("s3_hold", 32'(ir_out_o), 32'd1);
        ir_taken_i = 1'b1;
        cyc();
        ir_taken_i = 1'b0;
        chk("s3_taken_ir_out", 32'(ir_out_o), 32'd0);
        chk("s3_svc_busy", 32'(busy_o), 32'd1);
        rd(2'd1, rd_val); chk("s3_pend_clr", rd_val, 32'h00);
        rd(2'd2, rd_val); chk("s3_isr", rd_val, 32'h8000_0003);
        eret_i = 1'b1;
        cyc();
        eret_i = 1'b0;
        chk("s3_eret_busy", 32'(busy_o), 32'd0);
        chk("s3_eret_ir_out", 32'(ir_out_o), 32'd0);

        // Simultaneous edges on bits 5 and 2
        src_i = 8'h24;
        cyc();
        src_i = 8'h00;
        cyc();
        chk("p_first_req", 32'(ir_out_o), 32'd1);
        chk("p_first_id", 32'(ir_id_o), 32'd2);
        ir_taken_i = 1'b1;
        cyc();
        ir_taken_i = 1'b0;
        rd(2'd1, rd_val); chk("p_pend_left", rd_val, 32'h20);
        eret_i = 1'b1;
        cyc();
        eret_i = 1'b0;
        chk("p_idle_after_eret", 32'(busy_o), 32'd0);
        cyc();
        chk("p_second_req", 32'(ir_out_o), 32'd1);
        chk("p_second_id", 32'(ir_id_o), 32'd5);
        ir_taken_i = 1'b1;
        cyc();
        ir_taken_i = 1'b0;
        eret_i = 1'b1;
        cyc();
        eret_i = 1'b0;

        // Mask drop while requesting
        src_i = 8'h10;
        cyc();
        src_i = 8'h00;
        cyc();
        chk("m_req", 32'(ir_out_o), 32'd1);
        chk("m_req_id", 32'(ir_id_o), 32'd4);
        wr(2'd0, 32'h00);
        cyc();
        chk("m_drop_ir_out", 32'(ir_out_o), 32'd0);
        chk("m_drop_busy", 32'(busy_o), 32'd0);
        rd(2'd1, rd_val); chk("m_pend_kept", rd_val, 32'h10);
        wr(2'd1, 32'h10);
        rd(2'd1, rd_val); chk("m_pend_w1c", rd_val, 32'h00);
        chk("m_still_idle", 32'(ir_out_o), 32'd0);

        // Level mode, sources 0 and 1 held high
        wr(2'd3, 32'h00);
        wr(2'd0, 32'h03);
        src_i = 8'h03;
        cyc();
        cyc();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("lvl_req_%0d", k), 32'(ir_out_o), 32'd1);
            chk($sformatf("lvl_id_%0d", k), 32'(ir_id_o), 32'(rr_exp[k]));
            if (k < 2) begin
                ir_taken_i = 1'b1;
                cyc();
                ir_taken_i = 1'b0;
                eret_i = 1'b1;
                cyc();
                eret_i = 1'b0;
                cyc();
            end
        end

        // Reset while in service with PEND=0x40
        src_i = 8'h00;
        ir_taken_i = 1'b1;
        cyc();
        ir_taken_i = 1'b0;
        wr(2'd1, 32'hFF);
        wr(2'd3, 32'hFF);
        src_i = 8'h40;
        cyc();
        src_i = 8'h00;
        rd(2'd1, rd_val); chk("r_pend_pre", rd_val, 32'h40);
        chk("r_svc_busy", 32'(busy_o), 32'd1);
        rst_i = 1'b1;
        cyc();
        rst_i = 1'b0;
        chk("r_ir_out", 32'(ir_out_o), 32'd0);
        chk("r_busy", 32'(busy_o), 32'd0);
        chk("r_ir_id", 32'(ir_id_o), 32'd0);
        chk("r_rdata", cfg_rdata_o, 32'd0);
        rd(2'd1, rd_val); chk("r_pend", rd_val, 32'h00);
        rd(2'd3, rd_val); chk("r_mode", rd_val, 32'hFF);
        eret_i = 1'b1;
        cyc();
        eret_i = 1'b0;
        chk("r_eret_busy", 32'(busy_o), 32'd0);
        chk("r_eret_ir_out", 32'(ir_out_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
